// File: rtl/ser_stream_feeder.sv
// ser_stream_feeder
//
// Purpose:
//   Parallel-in, serial-out stage that feeds the serial input x_i of the
//   12-bit sequence detector. WIDTH-bit words are taken over a valid/ready
//   handshake and emitted one bit per clock. A one-entry holding register
//   lets consecutive words stream with no idle bit between them, so the
//   detector can see patterns that straddle word boundaries.
//
// Configuration:
//   SER_FEEDER_LSB_FIRST_EN - when defined, words are shifted out LSB first.
//                             When undefined (default), words go MSB first.
//                             Handshake, latency and last_o timing are the
//                             same in both builds.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high reset
//   data_i     in   [WIDTH-1:0] parallel word to serialise
//   valid_i    in   data_i is valid
//   ready_o    out  feeder can accept a word this cycle (registered)
//   ser_o      out  serial bit, forced to 0 when ser_vld_o is low
//   ser_vld_o  out  ser_o carries a word bit this cycle
//   last_o     out  ser_o is the final bit of the current word
//   busy_o     out  a word is being shifted or is held

module ser_stream_feeder #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             ser_o,
  output logic             ser_vld_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [WIDTH-1:0] holdReg_q, holdReg_d;
  logic [CW-1:0]    bitCnt_q, bitCnt_d;
  logic             holdFull_q, holdFull_d;
  logic             last_q, last_d;
  logic             accept;
  logic [WIDTH-1:0] shifted;
  logic             serBit;

  // A word is taken whenever the holding register is free; ready_o comes
  // straight from the hold flag so there is no path from valid_i to ready_o.
  assign accept = valid_i & ~holdFull_q;

  // The bit on the wire is always the tap end of the shift register; the
  // register is cleared on the way back to IDLE so ser_o idles at 0 without
  // any gating.
`ifdef SER_FEEDER_LSB_FIRST_EN
  assign shifted = {1'b0, shiftReg_q[WIDTH-1:1]};
  assign serBit  = shiftReg_q[0];
`else
  assign shifted = {shiftReg_q[WIDTH-2:0], 1'b0};
  assign serBit  = shiftReg_q[WIDTH-1];
`endif

  // Next-state logic. In SHIFT, the counter tracks which bit is on the
  // wire; when the final bit is showing, the next word comes from the hold
  // register first, then from a direct accept, otherwise we fall idle.
  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    holdReg_d  = holdReg_q;
    bitCnt_d   = bitCnt_q;
    holdFull_d = holdFull_q;
    last_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          shiftReg_d = data_i;
          bitCnt_d   = '0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        if (bitCnt_q != LAST_IDX) begin
          shiftReg_d = shifted;
          bitCnt_d   = bitCnt_q + CW'(1);
          last_d     = (bitCnt_q == LAST_IDX - CW'(1));
          if (accept) begin
            holdReg_d  = data_i;
            holdFull_d = 1'b1;
          end
        end else if (holdFull_q) begin
          shiftReg_d = holdReg_q;
          holdFull_d = 1'b0;
          bitCnt_d   = '0;
        end else if (accept) begin
          shiftReg_d = data_i;
          bitCnt_d   = '0;
        end else begin
          shiftReg_d = '0;
          bitCnt_d   = '0;
          state_d    = IDLE;
        end
      end

      default: begin
        shiftReg_d = '0;
        bitCnt_d   = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // State register; reset throws away both the partial and the held word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      holdReg_q  <= '0;
      bitCnt_q   <= '0;
      holdFull_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      holdReg_q  <= holdReg_d;
      bitCnt_q   <= bitCnt_d;
      holdFull_q <= holdFull_d;
      last_q     <= last_d;
    end
  end

  assign ready_o   = ~holdFull_q;
  assign ser_o     = serBit;
  assign ser_vld_o = (state_q == SHIFT);
  assign last_o    = last_q;
  assign busy_o    = (state_q == SHIFT) | holdFull_q;

endmodule

// File: tb/tb_ser_stream_feeder.sv
// tb_ser_stream_feeder
//
// Purpose:
//   Self-checking bench for ser_stream_feeder. The reference model is a
//   queue of expected wire bits: each accepted word appends its WIDTH bits,
//   and each clock retires the bit that was on the wire. The feeder can
//   accept whenever no more than one word's worth of bits is still pending.
//
// Ports: none (top-level bench).

module tb_ser_stream_feeder;

  localparam int WIDTH = 12;

  typedef struct packed {
    logic b;
    logic l;
  } wireBit_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic             ser_o;
  logic             ser_vld_o;
  logic             last_o;
  logic             busy_o;

  wireBit_t expQ[$];
  int       vectorCount = 0;
  int       missCount = 0;

  ser_stream_feeder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ser_o     (ser_o),
    .ser_vld_o (ser_vld_o),
    .last_o    (last_o),
    .busy_o    (busy_o)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Append a word's bits in wire order, flagging the final one.
  function automatic void pushWord(input logic [WIDTH-1:0] w);
    for (int k = 0; k < WIDTH; k++) begin
      wireBit_t e;
`ifdef SER_FEEDER_LSB_FIRST_EN
      e.b = w[k];
`else
      e.b = w[WIDTH-1-k];
`endif
      e.l = (k == WIDTH - 1);
      expQ.push_back(e);
    end
  endfunction

  function automatic logic modelReady();
    return (expQ.size() <= WIDTH);
  endfunction

  // Compare every output against the model's view of the current cycle.
  task automatic checkAll(input string ctx);
    logic expVld, expSer, expLast;
    expVld  = (expQ.size() > 0);
    expSer  = expVld ? expQ[0].b : 1'b0;
    expLast = expVld ? expQ[0].l : 1'b0;
    checkOutput({ctx, ".ser_vld"}, 32'(ser_vld_o), 32'(expVld));
    checkOutput({ctx, ".ser"},     32'(ser_o),     32'(expSer));
    checkOutput({ctx, ".last"},    32'(last_o),    32'(expLast));
    checkOutput({ctx, ".busy"},    32'(busy_o),    32'(expVld));
    checkOutput({ctx, ".ready"},   32'(ready_o),   32'(modelReady()));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check
  // outputs on the following falling edge.
  task automatic applyStimulus(input string ctx, input logic v,
                               input logic [WIDTH-1:0] d);
    logic acc;
    valid_i = v;
    data_i  = d;
    @(posedge clk);
    if (reset) begin
      expQ.delete();
    end else begin
      acc = v && modelReady();
      if (expQ.size() > 0) void'(expQ.pop_front());
      if (acc) pushWord(d);
    end
    @(negedge clk);
    checkAll(ctx);
  endtask

  task automatic idleCycles(input string ctx, input int n);
    for (int i = 0; i < n; i++) applyStimulus(ctx, 1'b0, '0);
  endtask

  // Asynchronous reset in the middle of a cycle, held across one edge.
  task automatic midReset(input string ctx);
    #2 reset = 1'b1;
    expQ.delete();
    #1 checkAll({ctx, ".async"});
    applyStimulus({ctx, ".held"}, 1'b0, '0);
    reset = 1'b0;
  endtask

  // Offer a word until the model says it is taken.
  task automatic offerUntilTaken(input string ctx, input logic [WIDTH-1:0] d);
    int guard;
    guard = 0;
    while (!modelReady() && guard < 4 * WIDTH) begin
      applyStimulus(ctx, 1'b1, d);
      guard++;
    end
    applyStimulus(ctx, 1'b1, d);
  endtask

  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] firstWord;

  initial begin
    $display("[TB] ser_stream_feeder bench, WIDTH=%0d", WIDTH);

    // Reset state.
    #2 reset = 1'b1;
    #1 checkAll("reset");
    @(negedge clk);
    reset = 1'b0;
    idleCycles("post_reset", 2);

    // Single word; the captured wire pattern must read EDB in both builds.
`ifdef SER_FEEDER_LSB_FIRST_EN
    firstWord = 12'hDB7;
`else
    firstWord = 12'hEDB;
`endif
    applyStimulus("single.acc", 1'b1, firstWord);
    capture = '0;
    for (int k = 0; k < WIDTH; k++) begin
      capture = {capture[WIDTH-2:0], ser_o};
      checkOutput("single.last_pos", 32'(last_o), 32'(k == WIDTH - 1));
      if (k < WIDTH - 1) applyStimulus("single", 1'b0, '0);
    end
    checkOutput("single.pattern", 32'(capture), 32'h0000_0EDB);
    applyStimulus("single.end", 1'b0, '0);
    checkOutput("single.vld_after", 32'(ser_vld_o), 32'h0);
    checkOutput("single.busy_after", 32'(busy_o), 32'h0);
    idleCycles("single.idle", 2);

    // Back-to-back with valid held high, plus backpressure on 12'h123.
    applyStimulus("b2b.w1", 1'b1, 12'hEDB);
    applyStimulus("b2b.w2", 1'b1, 12'hB6D);
    offerUntilTaken("bp.w3", 12'h123);
    idleCycles("b2b.drain", 3 * WIDTH + 2);

    // Gap between words.
    applyStimulus("gap.w1", 1'b1, 12'hFFF);
    idleCycles("gap.idle", 20);
    applyStimulus("gap.w2", 1'b1, 12'h000);
    checkOutput("gap.first_bit_vld", 32'(ser_vld_o), 32'h1);
    idleCycles("gap.drain", WIDTH + 1);

    // Reset during bit 5 with a word held.
    applyStimulus("rst.w1", 1'b1, 12'hEDB);
    applyStimulus("rst.w2", 1'b1, 12'hB6D);
    idleCycles("rst.shift", 4);
    midReset("rst");
    checkOutput("rst.ready_after", 32'(ready_o), 32'h1);
    idleCycles("rst.quiet", WIDTH + 4);
    applyStimulus("rst.next", 1'b1, 12'hA5C);
    idleCycles("rst.next_drain", WIDTH + 1);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        midReset("rand.rst");
      end else begin
        applyStimulus("rand", ($urandom_range(0, 9) < 6),
                      WIDTH'($urandom));
      end
    end
    idleCycles("final_drain", 3 * WIDTH);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/ser_stream_feeder.md
Name: ser_stream_feeder

Overview:
- Parallel-in, serial-out stage that sits directly upstream of the 12-bit sequence detector and drives its serial input x_i.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock with a bit-valid qualifier and an end-of-word marker.
- A one-entry holding register lets back-to-back words stream with no idle bit between them, which the detector needs to see overlapping patterns across word boundaries.

Parameters:
- WIDTH, 12, bits per parallel word; legal range 2..32.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_i  input  WIDTH  parallel word to serialise.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  feeder can accept a word this cycle.
- ser_o  output  1  serial bit; connects to detector x_i.
- ser_vld_o  output  1  ser_o carries a word bit this cycle.
- last_o  output  1  ser_o is the final bit of the current word.
- busy_o  output  1  a word is being shifted or is held.

Behaviour:
- Reset values (async reset asserted): ser_o=0, ser_vld_o=0, last_o=0, busy_o=0, ready_o=1. Shift register, holding register, bit counter and FSM are cleared.
- Reset mid-word: the partial word and any held word are discarded. No further bits are emitted after reset deasserts until a new accept.
- Accept: occurs at a rising edge where valid_i=1 and ready_o=1.
- ready_o = ~hold_full, taken from a register. ready_o has no combinational path from valid_i.
- FSM has two states, IDLE and SHIFT. Internal state: shift register sr, counter cnt in 0..WIDTH-1, hold register hd with flag hold_full.
- IDLE, on accept: sr<=data_i (the hold register is bypassed), cnt<=0, go to SHIFT.
- IDLE, no accept: outputs stay 0.
- First-bit latency: the first bit appears on ser_o in the cycle after accept, with ser_vld_o=1.
- Outputs are registered.
- Bit order is MSB first by default: bit k of the word (k=0..WIDTH-1) is on ser_o in the (k+1)th cycle after the load.
- last_o=1 only while bit index WIDTH-1 is on ser_o.
- SHIFT, cnt<WIDTH-1: cnt increments each cycle. An accept in this state writes hd and sets hold_full, so ready_o=0 from the next cycle.
- SHIFT, cnt=WIDTH-1 (final bit on ser_o): the next word is chosen by priority.
  1. hold_full=1: sr<=hd, hold_full<=0, cnt<=0, stay in SHIFT. The next word's first bit follows immediately with no gap, and ready_o returns to 1 on the following cycle.
  2. Else, accept this cycle: sr<=data_i, cnt<=0, stay in SHIFT. No gap.
  3. Else: go to IDLE. The next cycle has ser_vld_o=0, ser_o=0, last_o=0.
- Simultaneous accept and hold drain cannot occur, because ready_o=0 whenever hold_full=1.
- Maximum sustained throughput is one word per WIDTH cycles with ser_vld_o continuously high.
- busy_o = (state==SHIFT) | hold_full.
- While ser_vld_o=0, ser_o is forced to 0.

Optional Feature:
- Macro: SER_FEEDER_LSB_FIRST_EN.
- Defined: the word is shifted LSB first, so bit index 0 on the wire is data_i[0]. All handshake, latency and last_o timing are unchanged.
- Undefined: MSB first, as described above.

Test Plan:
- Single word: reset, then accept data_i=12'hEDB once.
  - Cycles 1..12 after accept show ser_o = 1,1,1,0,1,1,0,1,1,0,1,1 with ser_vld_o=1.
  - last_o=1 only in cycle 12; cycle 13 shows ser_vld_o=0 and busy_o=0.
  - The detector fed by ser_o pulses det_o once.
- Back-to-back: valid_i held high with 12'hEDB then 12'hB6D.
  - 24 contiguous ser_vld_o=1 cycles with no gap.
  - ready_o=0 from the cycle after the second word is accepted into hold until the cycle after the first word's last bit.
  - last_o pulses in cycles 12 and 24.
- Gap: accept 12'hFFF, then valid_i=0 for 20 cycles, then accept 12'h000.
  - ser_vld_o=0 for exactly the idle cycles between the words.
  - The second word's first bit appears 1 cycle after its accept.
- Backpressure: while hold_full=1, drive valid_i=1 with 12'h123.
  - No accept occurs and hd is unchanged.
  - The word is accepted on the first cycle ready_o returns to 1 and is emitted immediately after the held word.
- Reset mid-word: assert reset during bit 5 of 12'hEDB with a word held.
  - All outputs go to 0 immediately and ready_o=1.
  - After deassert, no stray bits appear and the next accepted word starts at bit 0.
- With SER_FEEDER_LSB_FIRST_EN: accept 12'hDB7; ser_o = 1,1,1,0,1,1,0,1,1,0,1,1, so det_o pulses once.
